// File: rtl/sd_cmd_ctrl_pkg.sv
// Shared constants for the SD CMD-line sequencer: register map, STATUS layout,
// FSM encoding and the CRC7 generator polynomial.
package sd_cmd_ctrl_pkg;

  localparam logic [2:0] ADDR_ARG      = 3'd0;
  localparam logic [2:0] ADDR_CMD      = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_RESP_ARG = 3'd3;
  localparam logic [2:0] ADDR_RESP_IDX = 3'd4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_CRC_ERR = 3;
  localparam int STAT_END_ERR = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TX        = 3'd1;
  localparam logic [2:0] ST_WAIT_RESP = 3'd2;
  localparam logic [2:0] ST_RX        = 3'd3;
  localparam logic [2:0] ST_NRC       = 3'd4;

  // x^7 + x^3 + 1, with the x^7 term implied by the shift
  localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator: one message bit per enabled clk, MSB first.
module sd_crc7
  import sd_cmd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data,
  output logic [6:0] crc
);

  logic feedback;

  assign feedback = data ^ crc[6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      crc <= '0;
    else if (clear)
      crc <= '0;
    else if (enable)
      crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
  end

endmodule

// File: rtl/sd_cmd_ctrl.sv
// Avalon-MM slave that serialises a 48-bit SD command frame on the CMD line and
// optionally captures and checks the 48-bit response.
module sd_cmd_ctrl
  import sd_cmd_ctrl_pkg::*;
#(
  parameter int HALF_DIV     = 2,
  parameter int RESP_TIMEOUT = 64
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        sd_clk,
  output logic        cmd_out,
  output logic        cmd_oe,
  input  logic        cmd_in
);

  logic [7:0]  div_cnt;
  logic        div_wrap, rise_tick, fall_tick;
  logic [2:0]  state;
  logic [31:0] arg_reg, resp_arg;
  logic [5:0]  resp_idx;
  logic        resp_en, crc_skip;
  logic        done, timeout_flag, crc_err, end_err;
  logic [47:0] tx_shift;
  logic [44:0] rx_shift;
  logic [5:0]  bit_cnt;
  logic [15:0] wait_cnt;
  logic [4:0]  nrc_cnt;
  logic        wr, cmd_start, w1c;
  logic        crc_clear, crc_en, crc_data;
  logic [6:0]  crc;
  logic [31:0] status_word;

  assign div_wrap  = (div_cnt == 8'(HALF_DIV - 1));
  assign rise_tick = div_wrap & ~sd_clk;
  assign fall_tick = div_wrap & sd_clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      sd_clk  <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      sd_clk  <= ~sd_clk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  assign wr        = chipselect & ~write_n;
  assign cmd_start = wr && (address == ADDR_CMD) && (state == ST_IDLE);
  assign w1c       = wr && (address == ADDR_STATUS) && writedata[STAT_DONE];

  // One CRC engine is shared: TX uses it on fall ticks, RX reuses it after a clear.
  assign crc_clear = cmd_start || (state == ST_TX && fall_tick && bit_cnt == 6'd48);
  assign crc_data  = (state == ST_TX) ? tx_shift[47] : cmd_in;
  assign crc_en    = (state == ST_TX && fall_tick && bit_cnt < 6'd40) ||
                     (rise_tick && state == ST_WAIT_RESP && !cmd_in) ||
                     (rise_tick && state == ST_RX && bit_cnt < 6'd40);

  sd_crc7 u_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clear),
    .enable (crc_en),
    .data   (crc_data),
    .crc    (crc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      arg_reg      <= '0;
      resp_arg     <= '0;
      resp_idx     <= '0;
      resp_en      <= 1'b0;
      crc_skip     <= 1'b0;
      done         <= 1'b0;
      timeout_flag <= 1'b0;
      crc_err      <= 1'b0;
      end_err      <= 1'b0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      nrc_cnt      <= '0;
      cmd_out      <= 1'b1;
      cmd_oe       <= 1'b0;
    end else begin
      if (wr && address == ADDR_ARG)
        arg_reg <= writedata;
      if (w1c) begin
        done         <= 1'b0;
        timeout_flag <= 1'b0;
        crc_err      <= 1'b0;
        end_err      <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            resp_en      <= writedata[6];
            crc_skip     <= writedata[7];
            done         <= 1'b0;
            timeout_flag <= 1'b0;
            crc_err      <= 1'b0;
            end_err      <= 1'b0;
            tx_shift     <= {2'b01, writedata[5:0], arg_reg, 8'h01};
            bit_cnt      <= '0;
            state        <= ST_TX;
          end
        end
        ST_TX: begin
          if (fall_tick) begin
            if (bit_cnt == 6'd48) begin
              cmd_oe   <= 1'b0;
              cmd_out  <= 1'b1;
              wait_cnt <= '0;
              nrc_cnt  <= '0;
              state    <= resp_en ? ST_WAIT_RESP : ST_NRC;
            end else begin
              cmd_oe  <= 1'b1;
              bit_cnt <= bit_cnt + 6'd1;
              // CRC is final once 40 bits are fed; splice it in ahead of the end bit
              if (bit_cnt == 6'd40) begin
                cmd_out  <= crc[6];
                tx_shift <= {crc[5:0], 1'b1, 41'b0};
              end else begin
                cmd_out  <= tx_shift[47];
                tx_shift <= {tx_shift[46:0], 1'b0};
              end
            end
          end
        end
        ST_WAIT_RESP: begin
          if (rise_tick) begin
            if (!cmd_in) begin
              rx_shift <= {rx_shift[43:0], cmd_in};
              bit_cnt  <= 6'd1;
              state    <= ST_RX;
            end else if (wait_cnt == 16'(RESP_TIMEOUT - 1)) begin
              timeout_flag <= 1'b1;
              nrc_cnt      <= '0;
              state        <= ST_NRC;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end
        end
        ST_RX: begin
          if (rise_tick) begin
            rx_shift <= {rx_shift[43:0], cmd_in};
            bit_cnt  <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd47) begin
              if (!cmd_in)
                end_err <= 1'b1;
              if (!crc_skip && rx_shift[6:0] != crc)
                crc_err <= 1'b1;
              resp_arg <= rx_shift[38:7];
              resp_idx <= rx_shift[44:39];
              nrc_cnt  <= '0;
              state    <= ST_NRC;
            end
          end
        end
        ST_NRC: begin
          // 16 half-period ticks give 8 full sd_clk periods from either entry edge
          if (rise_tick || fall_tick) begin
            if (nrc_cnt == 5'd15) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              nrc_cnt <= nrc_cnt + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    status_word               = '0;
    status_word[STAT_BUSY]    = (state != ST_IDLE);
    status_word[STAT_DONE]    = done;
    status_word[STAT_TIMEOUT] = timeout_flag;
    status_word[STAT_CRC_ERR] = crc_err;
    status_word[STAT_END_ERR] = end_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      readdata <= '0;
    else begin
      case (address)
        ADDR_ARG:      readdata <= arg_reg;
        ADDR_STATUS:   readdata <= status_word;
        ADDR_RESP_ARG: readdata <= resp_arg;
        ADDR_RESP_IDX: readdata <= {26'b0, resp_idx};
        default:       readdata <= '0;
      endcase
    end
  end

  assign irq = done;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl: table of command/response transactions plus
// hand-written busy-guard, W1C and mid-frame reset sequences.
module tb_sd_cmd_ctrl;
  import sd_cmd_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq, sd_clk, cmd_out, cmd_oe;
  logic        cmd_in = 1'b1;

  int total = 0;
  int bad = 0;

  logic [47:0] tx_frame = '0;
  int          tx_bits = 0;

  typedef struct {
    logic [31:0] arg;
    logic [7:0]  cmd;
    bit          drive_resp;
    logic [47:0] resp_word;
    logic [47:0] exp_frame;
    logic [31:0] exp_status;
    logic [31:0] exp_resp_arg;
    logic [5:0]  exp_resp_idx;
  } vec_t;

  vec_t vecs[6];

  sd_cmd_ctrl #(.HALF_DIV(2), .RESP_TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .sd_clk     (sd_clk),
    .cmd_out    (cmd_out),
    .cmd_oe     (cmd_oe),
    .cmd_in     (cmd_in)
  );

  always #5 clk = ~clk;

  // Card-side view of the line: bits are taken on sd_clk rising edges while driven.
  always @(posedge sd_clk) begin
    #1;
    if (cmd_oe === 1'b1) begin
      tx_frame = {tx_frame[46:0], cmd_out};
      tx_bits  = tx_bits + 1;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(posedge clk);
    #1;
    d = readdata;
  endtask

  task automatic waitOe(input logic level, input int budget);
    bit seen = 0;
    for (int n = 0; n < budget; n++) begin
      if (cmd_oe === level) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL oe_wait: cmd_oe never reached %0b within %0d clk", level, budget);
    end
  endtask

  task automatic waitIrq(input int budget, output int cycles);
    bit seen = 0;
    cycles = 0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (irq === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL irq_wait: irq not seen within %0d clk", budget);
    end
  endtask

  // Card model: after the host releases the line, idle 5 periods then send the response.
  task automatic driveResponse(input logic [47:0] word);
    waitOe(1'b1, 100);
    waitOe(1'b0, 600);
    repeat (5) @(negedge sd_clk);
    for (int i = 0; i < 48; i++) begin
      cmd_in = word[47 - i];
      @(negedge sd_clk);
    end
    cmd_in = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, output int cycles);
    writeReg(ADDR_ARG, v.arg);
    tx_frame = '0;
    tx_bits  = 0;
    writeReg(ADDR_CMD, {24'b0, v.cmd});
    if (v.drive_resp)
      driveResponse(v.resp_word);
    waitIrq(3000, cycles);
  endtask

  task automatic checkRow(input int idx, input vec_t v);
    logic [31:0] d;
    checkOutput($sformatf("row%0d_frame", idx), {16'b0, tx_frame}, {16'b0, v.exp_frame});
    checkOutput($sformatf("row%0d_bits", idx), tx_bits, 48);
    checkOutput($sformatf("row%0d_irq", idx), {63'b0, irq}, 64'd1);
    readReg(ADDR_STATUS, d);
    checkOutput($sformatf("row%0d_status", idx), d, v.exp_status);
    readReg(ADDR_RESP_ARG, d);
    checkOutput($sformatf("row%0d_resp_arg", idx), d, v.exp_resp_arg);
    readReg(ADDR_RESP_IDX, d);
    checkOutput($sformatf("row%0d_resp_idx", idx), d, {26'b0, v.exp_resp_idx});
  endtask

  initial begin
    logic [31:0] d;
    int          cycles;

    vecs[0] = '{32'h0,     8'h00, 1'b0, 48'h0,            48'h400000000095, 32'h02, 32'h0,     6'h00};
    vecs[1] = '{32'h1AA,   8'h48, 1'b1, 48'h08000001AA13, 48'h48000001AA87, 32'h02, 32'h1AA,   6'h08};
    vecs[2] = '{32'h1AA,   8'h48, 1'b0, 48'h0,            48'h48000001AA87, 32'h06, 32'h1AA,   6'h08};
    vecs[3] = '{32'h1AA,   8'h48, 1'b1, 48'h08000011AA13, 48'h48000001AA87, 32'h0A, 32'h11AA,  6'h08};
    vecs[4] = '{32'h1AA,   8'hC8, 1'b1, 48'h08000011AA13, 48'h48000001AA87, 32'h02, 32'h11AA,  6'h08};
    vecs[5] = '{32'h1AA,   8'h48, 1'b1, 48'h08000001AA12, 48'h48000001AA87, 32'h12, 32'h1AA,   6'h08};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_readdata", {32'b0, readdata}, 64'h0);
    checkOutput("reset_irq", {63'b0, irq}, 64'h0);
    checkOutput("reset_sd_clk", {63'b0, sd_clk}, 64'h0);
    checkOutput("reset_cmd_out", {63'b0, cmd_out}, 64'h1);
    checkOutput("reset_cmd_oe", {63'b0, cmd_oe}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    readReg(ADDR_STATUS, d);
    checkOutput("reset_status", d, 32'h0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], cycles);
      if (i == 0) begin
        total++;
        if (cycles < 224 || cycles > 229) begin
          bad++;
          $display("[TB] FAIL cmd0_latency: got %0d clk, expected 224..229", cycles);
        end
      end
      checkRow(i, vecs[i]);
    end

    // Busy guard: a second CMD during TX must be dropped.
    writeReg(ADDR_ARG, 32'h0);
    tx_frame = '0;
    tx_bits  = 0;
    writeReg(ADDR_CMD, 32'h00);
    repeat (40) @(posedge clk);
    writeReg(ADDR_CMD, 32'h48);
    waitIrq(3000, cycles);
    repeat (100) @(posedge clk);
    #1;
    checkOutput("guard_frame", {16'b0, tx_frame}, 64'h400000000095);
    checkOutput("guard_bits", tx_bits, 48);
    readReg(ADDR_STATUS, d);
    checkOutput("guard_status", d, 32'h02);
    readReg(ADDR_ARG, d);
    checkOutput("arg_readback", d, 32'h0);

    writeReg(ADDR_STATUS, 32'h2);
    readReg(ADDR_STATUS, d);
    checkOutput("w1c_status", d, 32'h0);
    checkOutput("w1c_irq", {63'b0, irq}, 64'h0);

    // Reset at bit 20 of a frame, then a clean CMD0.
    tx_frame = '0;
    tx_bits  = 0;
    writeReg(ADDR_CMD, 32'h00);
    for (int n = 0; n < 400 && tx_bits < 20; n++) @(posedge clk);
    checkOutput("midtx_reached", tx_bits, 20);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midtx_cmd_oe", {63'b0, cmd_oe}, 64'h0);
    checkOutput("midtx_cmd_out", {63'b0, cmd_out}, 64'h1);
    checkOutput("midtx_readdata", {32'b0, readdata}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    readReg(ADDR_STATUS, d);
    checkOutput("midtx_status", d, 32'h0);
    applyStimulus(vecs[0], cycles);
    checkRow(6, vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
